// File: rtl/unpool_2x2.sv
// unpool_2x2: inverts 2x2 binary max pooling by nearest-neighbour expansion.
// One pooled row of W bits is buffered, then replayed as two identical output
// rows of 2W bits, each input bit doubled horizontally.
module unpool_2x2 #(
  parameter int unsigned W  = 16,
  parameter int unsigned WB = 5
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iCLR,
  input  logic iEN,
  input  logic iDATA,
  output logic oREADY,
  input  logic iREADY,
  output logic oVALID,
  output logic oDATA,
  output logic oEOL
);

  localparam logic [WB-1:0] LastLd  = WB'(W - 1);
  localparam logic [WB-1:0] LastCol = WB'(2 * W - 1);
  localparam logic [WB-1:0] One     = WB'(1);

  typedef enum logic [1:0] {
    StLoad,
    StEmit0,
    StEmit1
  } stateE;

  stateE         stateQ, stateD;
  logic [WB-1:0] ldCntQ, ldCntD;
  logic [WB-1:0] colQ, colD;
  logic [W-1:0]  rowQ, rowD;
  logic [WB-1:0] halfCol;
  logic          rdBit;
  logic          colLast;

  assign colLast = (colQ == LastCol);
  assign halfCol = colQ >> 1;

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stateQ <= StLoad;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic; a frame clear always wins
  always_comb begin
    stateD = stateQ;
    if (iCLR) begin
      stateD = StLoad;
    end else begin
      unique case (stateQ)
        StLoad:  if (iEN && (ldCntQ == LastLd)) stateD = StEmit0;
        StEmit0: if (iREADY && colLast) stateD = StEmit1;
        StEmit1: if (iREADY && colLast) stateD = StLoad;
        default: stateD = StLoad;
      endcase
    end
  end

  // Datapath registers: load counter, output column, row buffer
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ldCntQ <= '0;
      colQ   <= '0;
      rowQ   <= '0;
    end else begin
      ldCntQ <= ldCntD;
      colQ   <= colD;
      rowQ   <= rowD;
    end
  end

  // Datapath next-state; the buffer is only written while loading
  always_comb begin
    ldCntD = ldCntQ;
    colD   = colQ;
    rowD   = rowQ;
    if (iCLR) begin
      ldCntD = '0;
      colD   = '0;
      rowD   = '0;
    end else begin
      unique case (stateQ)
        StLoad: begin
          if (iEN) begin
            for (int unsigned i = 0; i < W; i++) begin
              if (ldCntQ == WB'(i)) rowD[i] = iDATA;
            end
            if (ldCntQ == LastLd) begin
              ldCntD = '0;
              colD   = '0;
            end else begin
              ldCntD = ldCntQ + One;
            end
          end
        end
        StEmit0, StEmit1: begin
          if (iREADY) colD = colLast ? '0 : colQ + One;
        end
        default: begin
          ldCntD = '0;
          colD   = '0;
        end
      endcase
    end
  end

  // Buffer read mux: output column c shows pooled bit c/2
  always_comb begin
    rdBit = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (halfCol == WB'(i)) rdBit = rowQ[i];
    end
  end

  // Outputs; everything is forced low while reset is held
  always_comb begin
    oREADY = (stateQ == StLoad) && !iRST;
    oVALID = (stateQ != StLoad) && !iRST;
    oDATA  = oVALID && rdBit;
    oEOL   = oVALID && colLast;
  end

endmodule

// File: tb/tb_unpool_2x2.sv
// tb_unpool_2x2: directed and random stimulus against a queue-based model.
// The model turns each completed input row into the list of 4W output bits
// it must produce, and pops one per accepted output.
module tb_unpool_2x2;

  localparam int unsigned W  = 4;
  localparam int unsigned WB = 3;

  logic iCLK = 1'b0;
  logic iRST, iCLR, iEN, iDATA, iREADY;
  logic oREADY, oVALID, oDATA, oEOL;

  typedef struct {
    logic d;
    logic e;
  } outBitT;

  outBitT       expQ[$];
  logic [W-1:0] ldRow;
  int           ldN;
  int           nCmp;
  int           nBad;
  int           validCnt;
  int           eolCnt;

  always #5 iCLK = ~iCLK;

  unpool_2x2 #(
    .W (W),
    .WB(WB)
  ) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iCLR  (iCLR),
    .iEN   (iEN),
    .iDATA (iDATA),
    .oREADY(oREADY),
    .iREADY(iREADY),
    .oVALID(oVALID),
    .oDATA (oDATA),
    .oEOL  (oEOL)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nBad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkN(input string tag, input int obs, input int exp);
    nCmp++;
    assert (obs == exp)
    else begin
      nBad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    ldN  = 0;
    ldRow = '0;
  endtask

  // One rising edge of the reference: busy while output bits are pending
  task automatic modelEdge(input logic en, input logic d, input logic rdy, input logic clr);
    outBitT ob;
    if (clr) begin
      modelReset();
    end else if (expQ.size() != 0) begin
      if (rdy) expQ.delete(0);
    end else if (en) begin
      ldRow[ldN] = d;
      ldN++;
      if (ldN == int'(W)) begin
        for (int rep = 0; rep < 2; rep++) begin
          for (int c = 0; c < int'(2 * W); c++) begin
            ob.d = ldRow[c / 2];
            ob.e = (c == int'(2 * W - 1));
            expQ.push_back(ob);
          end
        end
        ldN = 0;
      end
    end
  endtask

  task automatic checkOuts(input string tag);
    logic expV;
    expV = (expQ.size() != 0);
    chk({tag, ".valid"}, oVALID, expV);
    chk({tag, ".ready"}, oREADY, !expV);
    if (expV) begin
      chk({tag, ".data"}, oDATA, expQ[0].d);
      chk({tag, ".eol"}, oEOL, expQ[0].e);
    end else begin
      chk({tag, ".data0"}, oDATA, 1'b0);
      chk({tag, ".eol0"}, oEOL, 1'b0);
    end
    if (oVALID === 1'b1) validCnt++;
    if (oEOL === 1'b1) eolCnt++;
  endtask

  task automatic step(input logic en, input logic d, input logic rdy, input logic clr,
                      input string tag);
    iEN    = en;
    iDATA  = d;
    iREADY = rdy;
    iCLR   = clr;
    @(posedge iCLK);
    modelEdge(en, d, rdy, clr);
    #1;
    checkOuts(tag);
  endtask

  // pat is written in arrival order: leftmost digit is the first bit sent
  task automatic loadRow(input logic [W-1:0] pat, input int gap, input string tag);
    for (int i = 0; i < int'(W); i++) begin
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b1, 1'b0, tag);
      step(1'b1, pat[W-1-i], 1'b1, 1'b0, tag);
    end
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic chkResetOuts(input string tag);
    chk({tag, ".valid"}, oVALID, 1'b0);
    chk({tag, ".ready"}, oREADY, 1'b0);
    chk({tag, ".data"}, oDATA, 1'b0);
    chk({tag, ".eol"}, oEOL, 1'b0);
  endtask

  initial begin
    nCmp = 0;
    nBad = 0;
    validCnt = 0;
    eolCnt = 0;
    modelReset();
    iRST = 1'b1;
    iCLR = 1'b0;
    iEN = 1'b0;
    iDATA = 1'b0;
    iREADY = 1'b0;

    // Power-on reset
    #1;
    chkResetOuts("por");
    @(posedge iCLK);
    @(posedge iCLK);
    #1;
    chkResetOuts("por_hold");
    iRST = 1'b0;
    #1;
    chk("por_rel.ready", oREADY, 1'b1);

    // Basic expansion: 1,0,1,1 -> 11001111 twice, 16 valid, 2 EOL
    loadRow(4'b1011, 0, "basic_ld");
    validCnt = 0;
    eolCnt = 0;
    // count starts after the 4th bit's check, so include it by hand
    if (oVALID === 1'b1) validCnt = 1;
    drain(4 * W + 2, "basic");
    chkN("basic.valid_cycles", validCnt, 16);
    chkN("basic.eol_count", eolCnt, 2);

    // Backpressure: iREADY toggling 1,0
    loadRow(4'b1011, 0, "bp_ld");
    for (int k = 0; k < int'(8 * W + 4); k++) step(1'b0, 1'b0, 1'(k % 2 == 0), 1'b0, "bp");

    // Gapped input: three idle cycles before each bit
    loadRow(4'b0100, 3, "gap");
    drain(4 * W + 1, "gap_out");

    // iEN held high with data 1 through the whole emit phase
    loadRow(4'b0110, 0, "busy_ld");
    for (int k = 0; k < int'(4 * W + W); k++) step(1'b1, 1'b1, 1'b1, 1'b0, "busy");
    drain(4 * W + 1, "busy_out");

    // Clear at col 3 of the second output row, colliding with iEN
    loadRow(4'b1011, 0, "clr_ld");
    for (int k = 0; k < int'(2 * W + 3); k++) step(1'b0, 1'b0, 1'b1, 1'b0, "clr_run");
    step(1'b1, 1'b1, 1'b1, 1'b1, "clr_hit");
    loadRow(4'b0110, 0, "clr_reld");
    drain(4 * W + 1, "clr_out");

    // Asynchronous reset after two bits of a row
    step(1'b1, 1'b1, 1'b1, 1'b0, "rst_ld");
    step(1'b1, 1'b0, 1'b1, 1'b0, "rst_ld");
    iEN = 1'b0;
    #2;
    iRST = 1'b1;
    #1;
    chkResetOuts("rst_mid");
    modelReset();
    @(posedge iCLK);
    #1;
    chkResetOuts("rst_hold");
    iRST = 1'b0;
    #1;
    chk("rst_rel.ready", oREADY, 1'b1);
    loadRow(4'b1101, 0, "rst_reld");
    drain(4 * W + 1, "rst_out");

    // Reset while emitting: nothing of the interrupted row may reappear
    loadRow(4'b1111, 0, "rst2_ld");
    drain(5, "rst2_run");
    #2;
    iRST = 1'b1;
    #1;
    chkResetOuts("rst2_mid");
    modelReset();
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    drain(6, "rst2_idle");
    loadRow(4'b0001, 0, "rst2_reld");
    drain(4 * W + 1, "rst2_out");

    // Random traffic with occasional clears
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0), "rand");
    end
    drain(8 * W, "rand_tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/unpool_2x2.md
UNPOOL_2X2 -- requirements
Module: unpool_2x2

Interface
REQ-001 Parameter W, default 16, number of bits in one input (pooled) row; W >= 2.
REQ-002 Parameter WB, default 5, width of the internal column counters; 2^WB >= 2*W.
REQ-003 iCLK  input  1  single clock, all state updates on its rising edge.
REQ-004 iRST  input  1  asynchronous, active-high reset.
REQ-005 iCLR  input  1  synchronous frame clear.
REQ-006 iEN  input  1  input bit valid.
REQ-007 iDATA  input  1  pooled feature-map bit.
REQ-008 oREADY  output  1  block accepts an input bit this cycle.
REQ-009 iREADY  input  1  downstream accepts an output bit this cycle.
REQ-010 oVALID  output  1  oDATA holds a valid upsampled bit.
REQ-011 oDATA  output  1  upsampled feature-map bit.
REQ-012 oEOL  output  1  current output bit is the last of an output row (column 2W-1).

Function
REQ-013 The block SHALL invert 2x2 binary max pooling by nearest-neighbour expansion: each input bit becomes a 2x2 block of identical output bits.
REQ-014 The FSM SHALL have exactly three states: LOAD, EMIT0, EMIT1.
REQ-015 LOAD: oREADY=1, oVALID=0; each cycle with iEN=1 stores iDATA at row-buffer index ldcnt, then increments ldcnt; iEN=0 holds state.
REQ-016 LOAD->EMIT0 SHALL occur on the cycle the W-th bit is accepted (ldcnt=W-1 and iEN=1); ldcnt returns to 0 and col is set to 0.
REQ-017 EMIT0/EMIT1: oREADY=0, oVALID=1, oDATA=BUF[col>>1], oEOL=(col==2W-1).
REQ-018 In EMIT states col SHALL increment only when iREADY=1; with iREADY=0, col, oDATA and oEOL SHALL hold.
REQ-019 Transitions: EMIT0->EMIT1 and EMIT1->LOAD when iREADY=1 and col=2W-1; col wraps to 0 on each transition.
REQ-020 Bit order: the first bit accepted in a row SHALL be the first two bits emitted in each output row.
REQ-021 Latency: the first output bit SHALL be valid the cycle after the W-th input bit is accepted; with iREADY held at 1 a row pair takes exactly 4W cycles.
REQ-022 iEN asserted outside LOAD SHALL be ignored; iDATA is not stored.
REQ-023 oDATA and oEOL SHALL be 0 whenever oVALID=0.
REQ-024 The row buffer SHALL NOT be modified in EMIT states; both output rows SHALL come from the same buffered row.
REQ-025 iCLR=1 SHALL, on the next clock edge, force LOAD, ldcnt=0, col=0 and buffer=0, overriding iEN and iREADY in the same cycle; the bit presented with iCLR is discarded.
REQ-026 iCLR in mid-EMIT SHALL truncate the output row with no further oVALID until a new W-bit row is loaded.

Reset
REQ-027 iRST=1 SHALL asynchronously force LOAD, ldcnt=0, col=0 and buffer=0.
REQ-028 While iRST=1, oVALID, oDATA and oEOL SHALL be 0, and oREADY SHALL be 0.
REQ-029 After iRST deassertion, oREADY SHALL be 1 from the first clock edge, with the block in LOAD.
REQ-030 iRST asserted mid-LOAD or mid-EMIT SHALL discard all partial data; no output bit from the interrupted row SHALL appear after release.

Verification (W=4, WB=3)
REQ-031 Basic expansion: input 1,0,1,1 with iEN=1 and iREADY=1 -> oDATA 1,1,0,0,1,1,1,1 twice, oVALID for 16 cycles, and oEOL on the 8th and 16th bits.
REQ-032 Backpressure: same input with iREADY toggling 1,0 -> oDATA sequence unchanged, each bit held while iREADY=0, and oEOL high only on col 7.
REQ-033 Gapped input: input 0,1,0,0 with iEN low for 3 cycles between bits -> oVALID rises exactly one cycle after the 4th accepted bit, giving 00110000 twice.
REQ-034 Ignore while busy: iEN=1 with iDATA=1 throughout EMIT0/EMIT1 -> buffer unchanged, and the next row starts loading only after EMIT1 ends.
REQ-035 Clear collision: iCLR=1 with iEN=1 at col=3 of EMIT1 -> next cycle oVALID=0, oREADY=1, ldcnt=0, and the next 4 accepted bits define a fresh output.
REQ-036 Reset mid-row: iRST pulse after 2 bits are loaded -> outputs 0 immediately; after release, a full 4-bit row 1,1,0,1 produces 11110011 twice.
